// File: rtl/ground_window_renderer.sv
// Ground strip renderer: shadow-latches the per-frame top-left coordinate and turns each
// scanned pixel into a tiled drawing request two cycles later, plus a per-frame pixel count.
module ground_window_renderer #(
    parameter int unsigned OBJECT_WIDTH  = 64,
    parameter int unsigned OBJECT_HEIGHT = 32,
    parameter int unsigned TILE_COUNT    = 10,
    parameter int unsigned COUNT_WIDTH   = 20
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          startOfFrame,
    input  logic signed [1:0][10:0]       coordinate,
    input  logic        [10:0]            pixelX,
    input  logic        [10:0]            pixelY,
    input  logic                          pixelValid,
    output logic                          drawingRequest,
    output logic        [10:0]            offsetX,
    output logic        [10:0]            offsetY,
    output logic        [3:0]             tileIndex,
    output logic        [COUNT_WIDTH-1:0] lastFramePixels
);
    localparam int unsigned CW      = 11;
    localparam int unsigned DW      = 13;
    localparam int unsigned TW      = 4;
    localparam int unsigned OW_LOG2 = $clog2(OBJECT_WIDTH);

    localparam logic signed [DW-1:0] STRIP_W  = DW'(OBJECT_WIDTH * TILE_COUNT);
    localparam logic signed [DW-1:0] TILE_H   = DW'(OBJECT_HEIGHT);
    localparam logic        [DW-1:0] OW_MASK  = DW'(OBJECT_WIDTH - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic        [CW-1:0]          lat_x_q, lat_x_d;
    logic        [CW-1:0]          lat_y_q, lat_y_d;
    logic signed [DW-1:0]          dx_q, dx_d;
    logic signed [DW-1:0]          dy_q, dy_d;
    logic                          v1_q, v1_d;
    logic                          draw_req_q, draw_req_d;
    logic        [CW-1:0]          offset_x_q, offset_x_d;
    logic        [CW-1:0]          offset_y_q, offset_y_d;
    logic        [TW-1:0]          tile_index_q, tile_index_d;
    logic        [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic        [COUNT_WIDTH-1:0] last_pix_q, last_pix_d;
    logic                          hit;

    // Shadow latch, two-stage pixel pipeline and per-frame counter
    always_comb begin
        lat_x_d      = lat_x_q;
        lat_y_d      = lat_y_q;
        cnt_d        = cnt_q;
        last_pix_d   = last_pix_q;
        offset_x_d   = '0;
        offset_y_d   = '0;
        tile_index_d = '0;

        if (startOfFrame) begin
            lat_x_d = coordinate[0];
            lat_y_d = coordinate[1];
        end

        // Pixel is unsigned, latched origin is sign-extended so negative origins clip
        dx_d = {2'b00, pixelX} - {{(DW - CW){lat_x_q[CW-1]}}, lat_x_q};
        dy_d = {2'b00, pixelY} - {{(DW - CW){lat_y_q[CW-1]}}, lat_y_q};
        v1_d = pixelValid;

        hit = v1_q && !dx_q[DW-1] && (dx_q < STRIP_W) && !dy_q[DW-1] && (dy_q < TILE_H);
        draw_req_d = hit;
        if (hit) begin
            offset_x_d   = CW'(dx_q & OW_MASK);
            offset_y_d   = CW'(dy_q);
            tile_index_d = TW'(dx_q >> OW_LOG2);
        end

        if (startOfFrame) begin
            last_pix_d = cnt_q;
            cnt_d      = draw_req_q ? COUNT_WIDTH'(1) : '0;
        end else if (draw_req_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_x_q      <= '0;
            lat_y_q      <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            v1_q         <= 1'b0;
            draw_req_q   <= 1'b0;
            offset_x_q   <= '0;
            offset_y_q   <= '0;
            tile_index_q <= '0;
            cnt_q        <= '0;
            last_pix_q   <= '0;
        end else begin
            lat_x_q      <= lat_x_d;
            lat_y_q      <= lat_y_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            v1_q         <= v1_d;
            draw_req_q   <= draw_req_d;
            offset_x_q   <= offset_x_d;
            offset_y_q   <= offset_y_d;
            tile_index_q <= tile_index_d;
            cnt_q        <= cnt_d;
            last_pix_q   <= last_pix_d;
        end
    end

    assign drawingRequest  = draw_req_q;
    assign offsetX         = offset_x_q;
    assign offsetY         = offset_y_q;
    assign tileIndex       = tile_index_q;
    assign lastFramePixels = last_pix_q;

endmodule

// File: tb/tb_ground_window_renderer.sv
// Directed bench for ground_window_renderer: vector table plus latency, reset, tearing and
// counter sequences; a second instance with an 8-bit counter covers saturation.
module tb_ground_window_renderer;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    startOfFrame;
    logic signed [1:0][10:0] coordinate;
    logic        [10:0]      pixelX, pixelY;
    logic                    pixelValid;
    logic                    drawingRequest;
    logic        [10:0]      offsetX, offsetY;
    logic        [3:0]       tileIndex;
    logic        [19:0]      lastFramePixels;
    logic                    dr8;
    logic        [10:0]      ox8, oy8;
    logic        [3:0]       ti8;
    logic        [7:0]       last8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ground_window_renderer dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .coordinate(coordinate),
        .pixelX(pixelX), .pixelY(pixelY), .pixelValid(pixelValid),
        .drawingRequest(drawingRequest), .offsetX(offsetX), .offsetY(offsetY),
        .tileIndex(tileIndex), .lastFramePixels(lastFramePixels)
    );

    ground_window_renderer #(.COUNT_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .coordinate(coordinate),
        .pixelX(pixelX), .pixelY(pixelY), .pixelValid(pixelValid),
        .drawingRequest(dr8), .offsetX(ox8), .offsetY(oy8),
        .tileIndex(ti8), .lastFramePixels(last8)
    );

    typedef struct {
        logic signed [10:0] cx;
        logic signed [10:0] cy;
        logic [10:0]        px;
        logic [10:0]        py;
        logic               valid;
        logic               exp_dr;
        logic [10:0]        exp_ox;
        logic [10:0]        exp_oy;
        logic [3:0]         exp_ti;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic dr, input int ox, input int oy, input int ti);
        check({name, ".dr"}, int'(drawingRequest), int'(dr));
        check({name, ".ox"}, int'(offsetX), ox);
        check({name, ".oy"}, int'(offsetY), oy);
        check({name, ".ti"}, int'(tileIndex), ti);
    endtask

    task automatic load_coord(input logic signed [10:0] cx, input logic signed [10:0] cy);
        pixelValid   = 1'b0;
        coordinate[0] = cx;
        coordinate[1] = cy;
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

    int cnt_dr;

    initial begin
        reset = 1'b1; startOfFrame = 1'b0; pixelValid = 1'b1;
        coordinate[0] = 11'sd0; coordinate[1] = 11'sd0;
        pixelX = 11'd5; pixelY = 11'd5;

        // Reset held with a hitting pixel on the bus
        repeat (3) step();
        check_out("reset", 1'b0, 0, 0, 0);
        check("reset.last", int'(lastFramePixels), 0);
        reset = 1'b0;
        step();
        check("flush.dr1", int'(drawingRequest), 0);
        step();
        check_out("after_reset", 1'b1, 5, 5, 0);

        // Exact two-cycle latency for an isolated pixel
        load_coord(11'sd100, 11'sd200);
        pixelX = 11'd100; pixelY = 11'd200; pixelValid = 1'b1;
        step();
        pixelValid = 1'b0;
        check("lat.cyc1", int'(drawingRequest), 0);
        step();
        check_out("lat.cyc2", 1'b1, 0, 0, 0);
        step();
        check("lat.cyc3", int'(drawingRequest), 0);

        vecs = '{
            '{11'sd100,  11'sd200, 11'd100, 11'd200, 1'b1, 1'b1, 11'd0,  11'd0,  4'd0},
            '{11'sd100,  11'sd200, 11'd99,  11'd200, 1'b1, 1'b0, 11'd0,  11'd0,  4'd0},
            '{11'sd0,    11'sd0,   11'd130, 11'd5,   1'b1, 1'b1, 11'd2,  11'd5,  4'd2},
            '{11'sd0,    11'sd0,   11'd640, 11'd5,   1'b1, 1'b0, 11'd0,  11'd0,  4'd0},
            '{-11'sd20,  -11'sd4,  11'd0,   11'd0,   1'b1, 1'b1, 11'd20, 11'd4,  4'd0},
            '{-11'sd20,  -11'sd4,  11'd0,   11'd28,  1'b1, 1'b0, 11'd0,  11'd0,  4'd0},
            '{11'sd0,    11'sd0,   11'd639, 11'd31,  1'b1, 1'b1, 11'd63, 11'd31, 4'd9},
            '{11'sd0,    11'sd0,   11'd639, 11'd32,  1'b1, 1'b0, 11'd0,  11'd0,  4'd0},
            '{11'sd100,  11'sd200, 11'd739, 11'd231, 1'b1, 1'b1, 11'd63, 11'd31, 4'd9},
            '{-11'sd20,  -11'sd4,  11'd619, 11'd27,  1'b1, 1'b1, 11'd63, 11'd31, 4'd9},
            '{-11'sd20,  -11'sd4,  11'd620, 11'd0,   1'b1, 1'b0, 11'd0,  11'd0,  4'd0},
            '{11'sd600,  11'sd470, 11'd5,   11'd470, 1'b1, 1'b0, 11'd0,  11'd0,  4'd0},
            '{-11'sd700, 11'sd0,   11'd0,   11'd0,   1'b1, 1'b0, 11'd0,  11'd0,  4'd0},
            '{-11'sd600, 11'sd0,   11'd0,   11'd3,   1'b1, 1'b1, 11'd24, 11'd3,  4'd9},
            '{11'sd0,    11'sd0,   11'd10,  11'd10,  1'b0, 1'b0, 11'd0,  11'd0,  4'd0}
        };
        for (int i = 0; i < vecs.size(); i++) begin
            load_coord(vecs[i].cx, vecs[i].cy);
            pixelX = vecs[i].px; pixelY = vecs[i].py; pixelValid = vecs[i].valid;
            step();
            step();
            check_out($sformatf("vec%0d", i), vecs[i].exp_dr, int'(vecs[i].exp_ox),
                      int'(vecs[i].exp_oy), int'(vecs[i].exp_ti));
        end

        // Coordinate change without SOF must not move the ground
        load_coord(11'sd0, 11'sd0);
        coordinate[0] = 11'sd300; coordinate[1] = 11'sd300;
        pixelX = 11'd130; pixelY = 11'd5; pixelValid = 1'b1;
        step();
        step();
        check_out("notear.hold", 1'b1, 2, 5, 2);
        // SOF-cycle pixel sees the old origin, the following pixel the new one
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        pixelX = 11'd300; pixelY = 11'd300;
        step();
        check_out("notear.sofpix", 1'b1, 2, 5, 2);
        pixelValid = 1'b0;
        step();
        check_out("notear.newpix", 1'b1, 0, 0, 0);

        // Frame count: rows 440..479 scanned, ground occupies rows 448..479
        step();
        step();
        load_coord(11'sd0, 11'sd448);
        cnt_dr = 0;
        for (int y = 440; y < 480; y++) begin
            for (int x = 0; x < 640; x++) begin
                pixelX = 11'(x); pixelY = 11'(y); pixelValid = 1'b1;
                step();
                if (drawingRequest) cnt_dr++;
            end
        end
        pixelValid = 1'b0;
        repeat (3) begin
            step();
            if (drawingRequest) cnt_dr++;
        end
        check("scan.dr_pulses", cnt_dr, 20480);
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        check("scan.last", int'(lastFramePixels), 20480);
        check("scan.last_sat8", int'(last8), 255);
        step();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        check("empty.last", int'(lastFramePixels), 0);
        check("empty.last8", int'(last8), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
